aes_cbc_stream_ctrl: RTL
========================

Name: aes_cbc_stream_ctrl

Overview:
Streaming front/back end for one AES-128 cipher core. It packs a 32-bit valid/ready input stream into 128-bit blocks and applies CBC chaining: the IV is XORed before encryption, or after decryption. It launches the core with a one-cycle load pulse, captures the result on done, and unpacks it onto a 32-bit valid/ready output stream. It sits between the system DMA/stream fabric and the cipher core, so the CPU no longer moves every block through APB registers.

Parameters:
TIMEOUT_CYC, 64, maximum cycles spent in WAIT before the block is abandoned (range 2..255)
CNT_W, 16, width of the processed-block counter

Ports:
vclk  in  1  clock; all logic on rising edge
vrst_n  in  1  synchronous reset, active low
mode_dec  in  1  0 = CBC encrypt, 1 = CBC decrypt; sampled only on the cycle the first word of a block is accepted
iv_in  in  128  initial chaining value
iv_load  in  1  pulse; loads iv_in into the chain register
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  32  input word; first word of a block maps to [127:96]
out_valid  out  1  output word valid
out_ready  in  1  output word consumed when out_valid & out_ready
out_data  out  32  output word; first word from [127:96]
core_ld  out  1  one-cycle start pulse to the cipher core
core_text_in  out  128  block presented to the core; held stable from core_ld until done or timeout
core_done  in  1  core result valid
core_text_out  in  128  core result
busy  out  1  high in any state except COLLECT with word count 0
err_timeout  out  1  sticky; cleared by iv_load or reset
blk_count  out  CNT_W  number of completed blocks; wraps modulo 2^CNT_W

Behaviour:
- Reset (vrst_n=0 at a clock edge) sets:
  - state COLLECT, word count 0, chain register 0, mode latch 0
  - in_ready=0 during reset and 1 on the first cycle after reset
  - out_valid=0, out_data=0, core_ld=0, core_text_in=0, busy=0, err_timeout=0, blk_count=0
- Reset mid-operation discards any partial block or result; no core_ld is issued afterwards.
- FSM states: COLLECT, LOAD, WAIT, EMIT.
- COLLECT:
  - in_ready=1. Each handshake stores in_data into slot cnt (0..3) and increments cnt.
  - The mode latch captures mode_dec when cnt=0.
  - On the handshake with cnt=3, go to LOAD.
- LOAD (exactly 1 cycle):
  - core_ld=1.
  - core_text_in = block ^ chain when encrypting; core_text_in = block when decrypting.
  - Next state is WAIT and the timeout counter clears.
- WAIT:
  - core_ld=0. core_done is ignored in every state except WAIT.
  - On core_done:
    - Encrypt: result = core_text_out; chain <= core_text_out.
    - Decrypt: result = core_text_out ^ chain (old chain); chain <= ciphertext block.
    - blk_count increments and the next state is EMIT.
  - If the counter reaches TIMEOUT_CYC without core_done:
    - err_timeout <= 1; chain and blk_count are unchanged.
    - The block is dropped, cnt <= 0, next state COLLECT.
- EMIT:
  - out_valid=1 with out_data = result word k, k = 0..3.
  - out_data stays stable while out_ready=0.
  - The handshake on k=3 returns to COLLECT with cnt=0. in_ready is 0 throughout EMIT.
- Latency: the 4th input handshake at edge N gives core_ld high in cycle N+1. core_done sampled at edge M gives out_valid=1 with word 0 in cycle M+1.
- iv_load is honoured only when busy=0. It writes chain <= iv_in and clears err_timeout. At other times it is ignored, with no side effect.
- iv_load coincident with the first input handshake: the IV load wins for the chaining value, and the word is still accepted.
- The XOR is bitwise over 128 bits; there is no other arithmetic. blk_count wraps from all-ones to 0 silently.

Test Plan:
- Core stub returns ~text_in three cycles after core_ld. IV=0, encrypt, stream words 00112233,44556677,8899aabb,ccddeeff -> exactly one core_ld pulse with core_text_in=00112233445566778899aabbccddeeff; output ffeeddcc,bbaa9988,77665544,33221100; blk_count=1.
- Same stub, second encrypt block all-zero words -> core_text_in = ffeeddccbbaa998877665544332211 00 (the previous ciphertext); output 00112233,44556677,8899aabb,ccddeeff; blk_count=2.
- Decrypt with iv_load IV=0000...0001, input block all-FF, stub output = text_in ^ 0 -> output words ffffffff,ffffffff,ffffffff,fffffffe; chain register = all-FF; a second all-FF block then outputs all-zero words.
- Hold out_ready=0 for 10 cycles during EMIT -> out_data stays at word 0 and in_ready=0; release -> four words in order with no loss or duplication.
- Core stub never asserts done -> err_timeout=1 exactly TIMEOUT_CYC=64 cycles after entering WAIT; state returns to COLLECT, blk_count unchanged, out_valid never asserts; a following iv_load clears err_timeout.
- Assert vrst_n=0 for one cycle after 2 input words -> all outputs at reset values; the next 4 words form a fresh block and no stale core_ld occurs.

Source files
------------

// File: rtl/aes_cbc_stream_ctrl_if.sv
// Bundle of stream, chaining-control and cipher-core signals for aes_cbc_stream_ctrl.
// slave: the controller's view. master: the view of whatever drives it (fabric + core model).
interface aes_cbc_stream_ctrl_if #(
    parameter int CNT_W = 16
);
    logic               mode_dec;
    logic [127:0]       iv_in;
    logic               iv_load;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic               core_ld;
    logic [127:0]       core_text_in;
    logic               core_done;
    logic [127:0]       core_text_out;
    logic               busy;
    logic               err_timeout;
    logic [CNT_W-1:0]   blk_count;

    modport slave (
        input  mode_dec, iv_in, iv_load, in_valid, in_data, out_ready,
               core_done, core_text_out,
        output in_ready, out_valid, out_data, core_ld, core_text_in,
               busy, err_timeout, blk_count
    );

    modport master (
        output mode_dec, iv_in, iv_load, in_valid, in_data, out_ready,
               core_done, core_text_out,
        input  in_ready, out_valid, out_data, core_ld, core_text_in,
               busy, err_timeout, blk_count
    );
endinterface

// File: rtl/aes_cbc_stream_ctrl.sv
// CBC stream controller for a single AES-128 core: packs 4x32-bit words into a
// block, applies CBC chaining around the core, and unpacks the result to 4x32.
module aes_cbc_stream_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 vclk,
    input  logic                 vrst_n,
    aes_cbc_stream_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

    // Last WAIT cycle index before the block is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t             r_state;
    state_t             w_state_next;

    logic [1:0]         r_cnt;          // input word slot
    logic [31:0]        r_slot [0:3];   // packed input words, slot 0 = [127:96]
    logic               r_mode;         // 1 = decrypt for the block in flight
    logic [127:0]       r_chain;        // CBC chaining value
    logic [127:0]       r_core_text;    // block presented to the core
    logic [127:0]       r_result;       // block being emitted
    logic [1:0]         r_k;            // output word index
    logic [7:0]         r_tmo;          // cycles spent in WAIT
    logic               r_err;
    logic [CNT_W-1:0]   r_blk_count;

    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_out_valid;
    logic               w_out_fire;
    logic               w_core_ld;
    logic               w_busy;
    logic               w_tmo_hit;
    logic [127:0]       w_block;
    logic [31:0]        w_out_data;

    // Full block as it stands on the handshake of the fourth word.
    assign w_block   = {r_slot[0], r_slot[1], r_slot[2], bus.in_data};
    assign w_busy    = !((r_state == ST_COLLECT) && (r_cnt == 2'd0));
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    // State register.
    always_ff @(posedge vclk) begin
        if (!vrst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake/strobe decode; in_ready is held low while reset is asserted.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_in_fire    = 1'b0;
        w_out_valid  = 1'b0;
        w_out_fire   = 1'b0;
        w_core_ld    = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                w_in_ready = vrst_n;
                w_in_fire  = w_in_ready && bus.in_valid;
                if (w_in_fire && (r_cnt == 2'd3)) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_core_ld    = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.core_done) begin
                    w_state_next = ST_EMIT;
                end else if (w_tmo_hit) begin
                    w_state_next = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                w_out_valid = 1'b1;
                w_out_fire  = bus.out_ready;
                if (w_out_fire && (r_k == 2'd3)) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    // Input word storage; contents need no reset because a slot is always written before use.
    always_ff @(posedge vclk) begin
        if (w_in_fire) begin
            r_slot[r_cnt] <= bus.in_data;
        end
    end

    // Datapath: word counting, CBC chaining, result capture, timeout and block counting.
    always_ff @(posedge vclk) begin
        if (!vrst_n) begin
            r_cnt       <= 2'd0;
            r_mode      <= 1'b0;
            r_chain     <= '0;
            r_core_text <= '0;
            r_result    <= '0;
            r_k         <= 2'd0;
            r_tmo       <= 8'd0;
            r_err       <= 1'b0;
            r_blk_count <= '0;
        end else begin
            if (w_in_fire) begin
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd0) begin
                    r_mode <= bus.mode_dec;
                end
                // Encrypt pre-XORs the chain; decrypt passes ciphertext straight through.
                if (r_cnt == 2'd3) begin
                    r_core_text <= r_mode ? w_block : (w_block ^ r_chain);
                end
            end

            if (r_state == ST_LOAD) begin
                r_tmo <= 8'd0;
            end else if (r_state == ST_WAIT) begin
                r_tmo <= r_tmo + 8'd1;
            end

            if (r_state == ST_WAIT) begin
                if (bus.core_done) begin
                    // Decrypt post-XORs the old chain and chains on the ciphertext it was given.
                    r_result    <= r_mode ? (bus.core_text_out ^ r_chain) : bus.core_text_out;
                    r_chain     <= r_mode ? r_core_text : bus.core_text_out;
                    r_blk_count <= r_blk_count + 1'b1;
                    r_k         <= 2'd0;
                end else if (w_tmo_hit) begin
                    r_err <= 1'b1;
                    r_cnt <= 2'd0;
                end
            end

            if (w_out_fire) begin
                r_k <= r_k + 2'd1;
            end

            // IV load only between blocks; it takes precedence for the chain on a first-word handshake.
            if (bus.iv_load && !w_busy) begin
                r_chain <= bus.iv_in;
                r_err   <= 1'b0;
            end
        end
    end

    // Output word mux; zero outside EMIT.
    always_comb begin
        w_out_data = 32'd0;
        if (r_state == ST_EMIT) begin
            case (r_k)
                2'd0:    w_out_data = r_result[127:96];
                2'd1:    w_out_data = r_result[95:64];
                2'd2:    w_out_data = r_result[63:32];
                default: w_out_data = r_result[31:0];
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_data     = w_out_data;
    assign bus.core_ld      = w_core_ld;
    assign bus.core_text_in = r_core_text;
    assign bus.busy         = w_busy;
    assign bus.err_timeout  = r_err;
    assign bus.blk_count    = r_blk_count;
endmodule
